// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package stream_arb_pkg;

  localparam int MAX_ID_W = 4;

  typedef struct packed {
    logic [MAX_ID_W-1:0] ptr;
    logic                locked;
    logic [MAX_ID_W-1:0] lock_id;
  } arb_state_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Requester-side and output-side handshake bundle of the arbiter.
interface stream_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = stream_arb_pkg::id_width(N_REQ)
) ();
  logic [N_REQ-1:0]       in_valid;
  logic [N_REQ-1:0]       in_ready;
  logic [N_REQ*WIDTH-1:0] in_data;
  logic [N_REQ-1:0]       in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_last;
  logic [ID_W-1:0]        out_id;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_id
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_id
  );
endinterface

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after i_ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt_onehot,
  output logic [ID_W-1:0]  o_gnt_idx,
  output logic             o_any
);
  always_comb begin
    int unsigned w_idx;
    o_gnt_onehot = '0;
    o_gnt_idx    = '0;
    o_any        = 1'b0;
    w_idx        = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = (32'(i_ptr) + k) % N_REQ;
      if (!o_any && i_req[w_idx]) begin
        o_any               = 1'b1;
        o_gnt_idx           = ID_W'(w_idx);
        o_gnt_onehot[w_idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output stage.
// Define STREAM_RR_ARB_LOCK_EN to hold the grant for a whole packet (until in_last).
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = id_width(N_REQ)
) (
  input logic               clk,
  input logic               reset,
  stream_rr_arbiter_if.slave bus
);
  logic [N_REQ-1:0] w_req;
  logic [ID_W-1:0]  w_ptr;
  logic [N_REQ-1:0] w_gnt_onehot;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_any;
  logic             w_load_ok;
  logic [WIDTH-1:0] w_data;
  logic             w_last;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [ID_W-1:0]  r_out_id;

`ifdef STREAM_RR_ARB_LOCK_EN
  arb_state_t r_state;

  // While locked the holder is the only candidate, so the grant waits on it even when idle.
  always_comb begin
    w_ptr = ID_W'(r_state.ptr);
    w_req = r_state.locked ? (bus.in_valid & (N_REQ'(1) << r_state.lock_id)) : bus.in_valid;
  end
`else
  logic [ID_W-1:0] r_ptr;

  always_comb begin
    w_ptr = r_ptr;
    w_req = bus.in_valid;
  end
`endif

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .i_req        (w_req),
    .i_ptr        (w_ptr),
    .o_gnt_onehot (w_gnt_onehot),
    .o_gnt_idx    (w_gnt_idx),
    .o_any        (w_any)
  );

  always_comb begin
    w_load_ok = !r_out_valid || bus.out_ready;
    w_last    = |(w_gnt_onehot & bus.in_last);
    w_data    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_gnt_onehot[i]) w_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign bus.in_ready  = (reset || !w_load_ok) ? '0 : w_gnt_onehot;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_id    = r_out_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_id    <= '0;
`ifdef STREAM_RR_ARB_LOCK_EN
      r_state     <= '0;
`else
      r_ptr       <= '0;
`endif
    end else if (w_load_ok) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_last  <= w_last;
        r_out_id    <= w_gnt_idx;
`ifdef STREAM_RR_ARB_LOCK_EN
        if (w_last) begin
          r_state.locked <= 1'b0;
          r_state.ptr    <= MAX_ID_W'(rr_next(32'(w_gnt_idx), N_REQ));
        end else begin
          r_state.locked  <= 1'b1;
          r_state.lock_id <= MAX_ID_W'(w_gnt_idx);
        end
`else
        r_ptr <= ID_W'(rr_next(32'(w_gnt_idx), N_REQ));
`endif
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed vector table plus random traffic against a reference model.
module tb_stream_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam logic [31:0] D = 32'hD3C2B1A5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_rr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
  stream_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit         rst;
    logic [3:0] v;
    logic [3:0] l;
    bit         ordy;
    logic [3:0] rdy;
    bit         ov;
    logic [7:0] od;
    logic [1:0] id;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int         m_ptr = 0;
  bit         m_locked = 0;
  int         m_lock_id = 0;
  bit         m_ov = 0;
  logic [7:0] m_od = '0;
  bit         m_ol = 0;
  int         m_id = 0;

  function automatic vec_t mk(bit rst, logic [3:0] v, logic [3:0] l, bit ordy,
                              logic [3:0] rdy, bit ov, logic [7:0] od, logic [1:0] id);
    vec_t r;
    r.rst = rst; r.v = v; r.l = l; r.ordy = ordy;
    r.rdy = rdy; r.ov = ov; r.od = od; r.id = id;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int m_winner(input logic [3:0] v);
`ifdef STREAM_RR_ARB_LOCK_EN
    if (m_locked) return v[m_lock_id] ? m_lock_id : -1;
`endif
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic m_clock(input bit rst, input logic [3:0] l, input logic [31:0] d,
                         input bit ordy, input int g);
    if (rst) begin
      m_ptr = 0; m_locked = 0; m_lock_id = 0;
      m_ov = 0; m_od = '0; m_ol = 0; m_id = 0;
    end else if (!m_ov || ordy) begin
      if (g >= 0) begin
        m_ov = 1; m_od = d[g*8 +: 8]; m_ol = l[g]; m_id = g;
`ifdef STREAM_RR_ARB_LOCK_EN
        if (l[g]) begin
          m_locked = 0;
          m_ptr = (g + 1) % N;
        end else begin
          m_locked = 1;
          m_lock_id = g;
        end
`else
        m_ptr = (g + 1) % N;
`endif
      end else begin
        m_ov = 0;
      end
    end
  endtask

  // Called at posedge+1; checks in_ready before the edge and registered outputs after it.
  task automatic step(input bit rst, input logic [3:0] v, input logic [3:0] l, input bit ordy,
                      input logic [31:0] d, input bit use_tab, input vec_t e);
    int g;
    logic [3:0] m_rdy;
    reset = rst; bus.in_valid = v; bus.in_last = l; bus.out_ready = ordy; bus.in_data = d;
    g = m_winner(v);
    m_rdy = (!rst && g >= 0 && (!m_ov || ordy)) ? (4'b0001 << g) : 4'b0000;
    #3;
    chk("in_ready", 32'(bus.in_ready), use_tab ? 32'(e.rdy) : 32'(m_rdy));
    @(posedge clk);
    m_clock(rst, l, d, ordy, g);
    #1;
    if (use_tab) begin
      chk("out_valid", 32'(bus.out_valid), 32'(e.ov));
      chk("out_data",  32'(bus.out_data),  32'(e.od));
      chk("out_id",    32'(bus.out_id),    32'(e.id));
    end else begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
      chk("out_data",  32'(bus.out_data),  32'(m_od));
      chk("out_last",  32'(bus.out_last),  32'(m_ol));
      chk("out_id",    32'(bus.out_id),    32'(m_id));
    end
  endtask

  vec_t tab[$];
  vec_t lock_tab[$];

  initial begin
    vec_t z;
    z = mk(0, '0, '0, 0, '0, 0, '0, '0);

    // reset then single requester
    tab.push_back(mk(1, 4'b0001, 4'b1111, 1, 4'b0000, 0, 8'h00, 2'd0));
    tab.push_back(mk(1, 4'b0001, 4'b1111, 1, 4'b0000, 0, 8'h00, 2'd0));
    tab.push_back(mk(0, 4'b0001, 4'b1111, 1, 4'b0001, 1, 8'hA5, 2'd0));
    // full contention: 1,2,3,0 follow without bubbles
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 8'hB1, 2'd1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 8'hC2, 2'd2));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 8'hD3, 2'd3));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 8'hA5, 2'd0));
    // backpressure for 5 cycles, then accept of id 1 on release
    for (int i = 0; i < 5; i++)
      tab.push_back(mk(0, 4'b0110, 4'b1111, 0, 4'b0000, 1, 8'hA5, 2'd0));
    tab.push_back(mk(0, 4'b0110, 4'b1111, 1, 4'b0010, 1, 8'hB1, 2'd1));
    // grant 2 moves ptr to 3, then wrap-and-skip back to 2
    tab.push_back(mk(0, 4'b0100, 4'b1111, 1, 4'b0100, 1, 8'hC2, 2'd2));
    tab.push_back(mk(0, 4'b0100, 4'b1111, 1, 4'b0100, 1, 8'hC2, 2'd2));
    // idle: valid drops, data and id hold
    tab.push_back(mk(0, 4'b0000, 4'b1111, 1, 4'b0000, 0, 8'hC2, 2'd2));
    tab.push_back(mk(0, 4'b1001, 4'b1111, 1, 4'b1000, 1, 8'hD3, 2'd3));
    tab.push_back(mk(0, 4'b1001, 4'b1111, 1, 4'b0001, 1, 8'hA5, 2'd0));
    tab.push_back(mk(0, 4'b0000, 4'b1111, 0, 4'b0000, 1, 8'hA5, 2'd0));
    // mid-transfer reset (beat with last=0 takes the lock when enabled)
    tab.push_back(mk(0, 4'b1000, 4'b0000, 1, 4'b1000, 1, 8'hD3, 2'd3));
    tab.push_back(mk(1, 4'b1111, 4'b1111, 0, 4'b0000, 0, 8'h00, 2'd0));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 8'hA5, 2'd0));

    // packet lock: requester 1 sends 3 beats while 2 waits; idle holder blocks 2
    lock_tab.push_back(mk(0, 4'b0110, 4'b0100, 1, 4'b0010, 1, 8'hB1, 2'd1));
    lock_tab.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0000, 0, 8'hB1, 2'd1));
    lock_tab.push_back(mk(0, 4'b0110, 4'b0100, 1, 4'b0010, 1, 8'hB1, 2'd1));
    lock_tab.push_back(mk(0, 4'b0110, 4'b0110, 1, 4'b0010, 1, 8'hB1, 2'd1));
    lock_tab.push_back(mk(0, 4'b0110, 4'b0110, 1, 4'b0100, 1, 8'hC2, 2'd2));

    reset = 1'b1; bus.in_valid = '0; bus.in_last = '0; bus.out_ready = 1'b0; bus.in_data = '0;
    @(posedge clk); #1;

    foreach (tab[i])
      step(tab[i].rst, tab[i].v, tab[i].l, tab[i].ordy, D, 1'b1, tab[i]);
`ifdef STREAM_RR_ARB_LOCK_EN
    foreach (lock_tab[i])
      step(lock_tab[i].rst, lock_tab[i].v, lock_tab[i].l, lock_tab[i].ordy, D, 1'b1, lock_tab[i]);
`endif

    step(1'b1, '0, '0, 1'b0, '0, 1'b0, z);
    for (int c = 0; c < 600; c++) begin
      logic [3:0] v;
      logic [3:0] l;
      v = 4'($urandom);
      l = 4'($urandom) | 4'($urandom);
      step($urandom_range(0, 49) == 0, v, l, $urandom_range(0, 3) != 0, $urandom, 1'b0, z);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin arbiter that shares one registered valid/ready output stage among `N_REQ` upstream streams. Each cycle it grants at most one requester, captures that beat into the output register with the winner's index, and advances a fairness pointer. It sits in front of downstream consumers that accept a single registered stream, such as shared pipeline stages, FIFOs or bus masters.

## Interface
- `N_REQ`, 4, number of requesters (2..16).
- `WIDTH`, 32, data width per beat.
- `ID_W`, `$clog2(N_REQ)` (minimum 1), width of `out_id`.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  N_REQ  per-requester valid.
- `in_ready`  out  N_REQ  per-requester ready; one-hot or zero.
- `in_data`  in  N_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- `in_last`  in  N_REQ  per-requester end-of-packet flag.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  downstream ready.
- `out_data`  out  WIDTH  registered winning beat.
- `out_last`  out  1  registered `in_last` of the winning beat.
- `out_id`  out  ID_W  index of the requester that supplied the current output beat.

## Operation
- Stage can load when `load_ok = !out_valid | out_ready`.
- Priority order each cycle runs `ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1`. The winner `g` is the first index with `in_valid[g]=1`.
- `in_ready[g] = load_ok`. Every other bit of `in_ready` is 0, and all bits are 0 when no request is pending.
- `in_ready` never depends on a requester's own `in_valid`, except through the winner selection.
- On accept (`in_valid[g] & in_ready[g]`):
  - `out_data <= in_data[g]`, `out_last <= in_last[g]`, `out_id <= g`, `out_valid <= 1`.
  - `ptr <= (g+1) mod N_REQ`, wrapping from N_REQ-1 to 0.
- If `load_ok` is 1 and no requester is valid, `out_valid <= 0`. Data, last and id hold.
- If `load_ok` is 0, all output registers and `ptr` hold.
- A stalled requester must hold valid/data stable; it is eventually granted within N_REQ accepted beats.
- Simultaneous downstream pop and new accept in the same cycle is required, giving 1 beat/cycle.
- `reset` (including mid-operation):
  - Clears `out_valid`, `out_data`, `out_last`, `out_id`, `ptr` and the lock state to 0.
  - Any beat held in the output register is discarded.
  - `in_ready` is all-0 in a reset cycle.

## Timing
- Latency: 1 cycle from accept to `out_valid`/`out_data` visible.
- Throughput: 1 beat/cycle sustained while `out_ready=1`. No bubble on requester switch.
- `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready`, `ptr` and the lock state.
- All outputs other than `in_ready` are registered.
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `out_id=0`, `in_ready=0`.

## Configuration
- Macro: `STREAM_RR_ARB_LOCK_EN`.
- Defined (packet lock):
  - Accepting a beat with `in_last=0` sets `locked=1` and `lock_id=g`.
  - While locked, only `lock_id` can be granted, even if idle. Other requesters see `in_ready=0`.
  - Accepting `lock_id`'s beat with `in_last=1` clears the lock.
  - `ptr` advances only on accepted `in_last=1` beats.
- Undefined (beat arbitration): arbitration is per beat and `in_last` is passed through only. The lock registers are not present.

## Structure
- Package `stream_arb_pkg` holds:
  - The `id_width(n)` function.
  - The `rr_next(ptr, n)` wrap helper.
  - The `arb_state_t` struct `{ptr, locked, lock_id}`.
- Sub-module `rr_pick`: combinational rotating priority encoder. Inputs are `req[N_REQ]` and `ptr`; outputs are `gnt_onehot`, `gnt_idx` and `any`. It is instantiated once. The top level holds the output register, pointer and lock.

## Test plan
- **Reset and single requester.** N_REQ=4, WIDTH=8. Hold `reset` for 2 cycles, then `in_valid=0001`, `in_data[0]=0xA5`, `out_ready=1`. Expect `in_ready=0000` during reset, then `out_valid=1`, `out_data=0xA5`, `out_id=0` one cycle after accept, and `ptr=1`.
- **Full contention.** `in_valid=1111` continuously, `out_ready=1`. Expect `out_id` sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
- **Backpressure.** `out_ready=0` with `out_valid=1`, `in_valid=0110`. Expect `in_ready=0000`, outputs hold for 5 cycles, then `out_ready=1` gives an accept of id 1 in the same cycle.
- **Wrap and skip.** `ptr=3`, `in_valid=0100`. Expect grant to 2 and `ptr` becomes 3.
- **Lock (with `STREAM_RR_ARB_LOCK_EN`).** Requester 1 sends 3 beats with last on beat 3 while requester 2 is valid throughout. Expect `out_id` 1,1,1 then 2.
- **Reset mid-transfer.** Assert `reset` while `out_valid=1` and `locked=1`. Next cycle expect `out_valid=0`, `ptr=0`, lock cleared, and requester 0 winning first.
